matmul_scheduler: RTL and testbench

Job scheduler and sequencer for the matrix-multiply PE array. It accepts matrix-multiply job descriptors through a valid/ready port and buffers them in a small FIFO. For each job it bounds-checks the operands against RAM, drives stable dimension and offset configuration to the array, and sequences the per-PE 2-bit start signals. It then collects per-PE completion, enforces a timeout, and reports done or error to the host side.

---
 rtl/matmul_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_matmul_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_scheduler.sv
// Job scheduler for the matmul PE array: descriptor FIFO, bounds check,
// per-PE start sequencing, completion collection and timeout.
module matmul_scheduler #(
  parameter int PE_COUNT    = 4,
  parameter int RAM_SIZE    = 128,
  parameter int QUEUE_DEPTH = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [31:0]              job_M,
  input  logic [31:0]              job_N,
  input  logic [31:0]              job_P,
  input  logic [31:0]              job_left_offset,
  input  logic [31:0]              job_right_offset,
  input  logic [31:0]              job_result_offset,
  output logic [31:0]              M,
  output logic [31:0]              N,
  output logic [31:0]              P,
  output logic [31:0]              left_offset,
  output logic [31:0]              right_offset,
  output logic [31:0]              result_offset,
  output logic [PE_COUNT-1:0][1:0] start_signal,
  input  logic [PE_COUNT-1:0]      pe_done,
  output logic                     busy,
  output logic                     job_done,
  output logic                     job_error,
  output logic [31:0]              cycle_count
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] n;
    logic [31:0] p;
    logic [31:0] lo;
    logic [31:0] ro;
    logic [31:0] so;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_RUN,
    S_ABORT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  job_t          mem_q [QUEUE_DEPTH];
  job_t          job_in;
  job_t          cfg_q, cfg_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          push, pop, full, empty;

  logic [PE_COUNT-1:0] mask_q, mask_d, mask_next;
  logic [31:0]         run_q, run_d;
  logic [31:0]         cc_q, cc_d;
  logic                err_q, err_d;

  logic [63:0] l_end, r_end, o_end;
  logic        reject;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
    return (a == AW'(QUEUE_DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  assign job_in = '{m: job_M, n: job_N, p: job_P,
                    lo: job_left_offset, ro: job_right_offset,
                    so: job_result_offset};

  assign full      = (fill_q == CW'(QUEUE_DEPTH));
  assign empty     = (fill_q == '0);
  assign job_ready = !full;
  assign push      = job_valid && !full;

  // 64-bit extents so huge dimensions cannot wrap past the RAM check
  always_comb begin
    l_end = {32'd0, cfg_q.lo} + ({32'd0, cfg_q.m} * {32'd0, cfg_q.n});
    r_end = {32'd0, cfg_q.ro} + ({32'd0, cfg_q.n} * {32'd0, cfg_q.p});
    o_end = {32'd0, cfg_q.so} + ({32'd0, cfg_q.m} * {32'd0, cfg_q.p});
    reject = (cfg_q.m == '0) || (cfg_q.n == '0) || (cfg_q.p == '0) ||
             (l_end > 64'(RAM_SIZE)) ||
             (r_end > 64'(RAM_SIZE)) ||
             (o_end > 64'(RAM_SIZE));
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    mask_d       = mask_q;
    mask_next    = mask_q | pe_done;
    run_d        = run_q;
    cc_d         = cc_q;
    err_d        = err_q;
    pop          = 1'b0;
    start_signal = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cfg_d   = mem_q[rd_q];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        run_d = '0;
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        for (int i = 0; i < PE_COUNT; i++) start_signal[i] = 2'b01;
        mask_d  = pe_done;
        run_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        for (int i = 0; i < PE_COUNT; i++)
          start_signal[i] = mask_q[i] ? 2'b00 : 2'b10;
        mask_d = mask_next;
        run_d  = run_q + 32'd1;
        if (&mask_next)
          state_d = S_DONE;
        else if (run_q + 32'd1 == 32'(TIMEOUT))
          state_d = S_ABORT;
      end
      S_ABORT: begin
        for (int i = 0; i < PE_COUNT; i++) start_signal[i] = 2'b11;
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        cc_d    = run_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pop never frees a slot for a push in the same cycle: full gates push
  always_comb begin
    wr_d   = push ? inc(wr_q) : wr_q;
    rd_d   = pop ? inc(rd_q) : rd_q;
    fill_d = fill_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= job_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      mask_q  <= '0;
      run_q   <= '0;
      cc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      mask_q  <= mask_d;
      run_q   <= run_d;
      cc_q    <= cc_d;
      err_q   <= err_d;
    end
  end

  assign M             = cfg_q.m;
  assign N             = cfg_q.n;
  assign P             = cfg_q.p;
  assign left_offset   = cfg_q.lo;
  assign right_offset  = cfg_q.ro;
  assign result_offset = cfg_q.so;
  assign busy          = (state_q != S_IDLE);
  assign job_done      = (state_q == S_DONE);
  assign job_error     = (state_q == S_DONE) && err_q;
  assign cycle_count   = cc_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler (TIMEOUT overridden to 8).
// Inputs and checks happen 1ns after each rising edge.
module tb_matmul_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            job_valid;
  logic            job_ready;
  logic [31:0]     job_M, job_N, job_P;
  logic [31:0]     job_left_offset, job_right_offset, job_result_offset;
  logic [31:0]     M, N, P, left_offset, right_offset, result_offset;
  logic [3:0][1:0] start_signal;
  logic [3:0]      pe_done;
  logic            busy, job_done, job_error;
  logic [31:0]     cycle_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] bm [4], bn [4], bp [4], blo [4], bro [4], bso [4];

  matmul_scheduler #(
    .PE_COUNT(4), .RAM_SIZE(128), .QUEUE_DEPTH(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_M(job_M), .job_N(job_N), .job_P(job_P),
    .job_left_offset(job_left_offset),
    .job_right_offset(job_right_offset),
    .job_result_offset(job_result_offset),
    .M(M), .N(N), .P(P),
    .left_offset(left_offset), .right_offset(right_offset),
    .result_offset(result_offset),
    .start_signal(start_signal), .pe_done(pe_done),
    .busy(busy), .job_done(job_done), .job_error(job_error),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] m, n, p, lo, ro, so);
    job_valid = 1'b1;
    job_M = m; job_N = n; job_P = p;
    job_left_offset = lo; job_right_offset = ro;
    job_result_offset = so;
  endtask

  task automatic test_reset();
    total++;
    if (job_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got %0h want 1", job_ready);
    end
    total++;
    if (busy !== 1'b0 || job_done !== 1'b0 || job_error !== 1'b0) begin
      bad++; $display("FAIL rst_flags got %b%b%b want 000", busy, job_done, job_error);
    end
    total++;
    if (start_signal !== 8'h00) begin
      bad++; $display("FAIL rst_start got %h want 00", start_signal);
    end
    total++;
    if (M !== 0 || N !== 0 || P !== 0 || result_offset !== 0 || cycle_count !== 0) begin
      bad++; $display("FAIL rst_cfg got M=%0h cc=%0h want 0", M, cycle_count);
    end
  endtask

  task automatic test_single();
    put(2, 2, 2, 0, 4, 8);
    step();
    job_valid = 1'b0;
    total++;
    if (job_ready !== 1'b1 || start_signal !== 8'h00) begin
      bad++; $display("FAIL single_t1 got rdy=%b ss=%h want 1/00", job_ready, start_signal);
    end
    step();
    total++;
    if (busy !== 1'b1 || M !== 2 || right_offset !== 4 || result_offset !== 8 ||
        start_signal !== 8'h00) begin
      bad++; $display("FAIL single_check got busy=%b M=%0d ss=%h want 1/2/00", busy, M, start_signal);
    end
    step();
    total++;
    if (start_signal !== 8'h55) begin
      bad++; $display("FAIL single_start got %h want 55", start_signal);
    end
    step();
    total++;
    if (start_signal !== 8'hAA) begin
      bad++; $display("FAIL single_run0 got %h want aa", start_signal);
    end
    pe_done = 4'b0001;
    step();
    total++;
    if (start_signal !== 8'hA8 || job_done !== 1'b0) begin
      bad++; $display("FAIL single_run1 got %h/%b want a8/0", start_signal, job_done);
    end
    pe_done = 4'b0110;
    step();
    total++;
    if (start_signal !== 8'h80 || job_done !== 1'b0) begin
      bad++; $display("FAIL single_run2 got %h/%b want 80/0", start_signal, job_done);
    end
    pe_done = 4'b1000;
    step();
    pe_done = 4'b0000;
    total++;
    if (job_done !== 1'b1 || job_error !== 1'b0 || start_signal !== 8'h00) begin
      bad++; $display("FAIL single_done got d=%b e=%b ss=%h want 1/0/00", job_done, job_error, start_signal);
    end
    step();
    total++;
    if (job_done !== 1'b0 || busy !== 1'b0 || cycle_count !== 32'd3) begin
      bad++; $display("FAIL single_after got d=%b busy=%b cc=%0d want 0/0/3", job_done, busy, cycle_count);
    end
  endtask

  task automatic test_reject(input string nm,
                             input logic [31:0] m, n, p, lo, ro, so);
    put(m, n, p, lo, ro, so);
    step();
    job_valid = 1'b0;
    total++;
    if (start_signal !== 8'h00 || job_done !== 1'b0) begin
      bad++; $display("FAIL %s_t1 got ss=%h d=%b want 00/0", nm, start_signal, job_done);
    end
    step();
    total++;
    if (start_signal !== 8'h00 || job_done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s_t2 got ss=%h d=%b b=%b want 00/0/1", nm, start_signal, job_done, busy);
    end
    step();
    total++;
    if (job_done !== 1'b1 || job_error !== 1'b1 || start_signal !== 8'h00) begin
      bad++; $display("FAIL %s_t3 got d=%b e=%b ss=%h want 1/1/00", nm, job_done, job_error, start_signal);
    end
    step();
    total++;
    if (job_done !== 1'b0 || job_error !== 1'b0 || busy !== 1'b0 || cycle_count !== 0) begin
      bad++; $display("FAIL %s_t4 got d=%b e=%b b=%b cc=%0d want 0/0/0/0", nm, job_done, job_error, busy, cycle_count);
    end
  endtask

  task automatic drive_b(input int k);
    put(bm[k], bn[k], bp[k], blo[k], bro[k], bso[k]);
  endtask

  task automatic test_back_to_back();
    int          done_n;
    int          wait_n;
    logic        pushed3;
    logic        pbusy;
    logic [31:0] pm, pn, pp, plo, pro, pso;
    drive_b(0);
    step();
    drive_b(1);
    step();
    drive_b(2);
    step();
    drive_b(3);
    done_n  = 0;
    wait_n  = 0;
    pushed3 = 1'b0;
    pbusy = busy;
    pm = M; pn = N; pp = P;
    plo = left_offset; pro = right_offset; pso = result_offset;
    for (int cyc = 0; cyc < 60 && done_n < 4; cyc++) begin
      if (M !== pm || N !== pn || P !== pp || left_offset !== plo ||
          right_offset !== pro || result_offset !== pso) begin
        total++;
        if (!(busy === 1'b1 && pbusy === 1'b0)) begin
          bad++; $display("FAIL b2b_cfg_change got busy=%b prev=%b want 1/0", busy, pbusy);
        end
      end
      pbusy = busy;
      pm = M; pn = N; pp = P;
      plo = left_offset; pro = right_offset; pso = result_offset;
      if (!pushed3) begin
        if (job_ready) pushed3 = 1'b1;
        else wait_n++;
      end
      pe_done = (start_signal === 8'h55) ? 4'hF : 4'h0;
      if (job_done === 1'b1) begin
        total++;
        if (M !== bm[done_n] || N !== bn[done_n] || P !== bp[done_n] ||
            left_offset !== blo[done_n] || right_offset !== bro[done_n] ||
            result_offset !== bso[done_n] || job_error !== 1'b0) begin
          bad++;
          $display("FAIL b2b_job%0d got M=%0d N=%0d P=%0d lo=%0d e=%b want %0d/%0d/%0d/%0d/0",
                   done_n, M, N, P, left_offset, job_error,
                   bm[done_n], bn[done_n], bp[done_n], blo[done_n]);
        end
        done_n++;
      end
      step();
      if (pushed3) job_valid = 1'b0;
    end
    pe_done   = 4'h0;
    job_valid = 1'b0;
    total++;
    if (done_n != 4) begin
      bad++; $display("FAIL b2b_count got %0d want 4", done_n);
    end
    total++;
    if (wait_n != 4) begin
      bad++; $display("FAIL b2b_ready_low got %0d want 4", wait_n);
    end
    step();
    step();
  endtask

  task automatic test_timeout();
    put(1, 1, 1, 0, 0, 0);
    step();
    job_valid = 1'b0;
    step();
    step();
    total++;
    if (start_signal !== 8'h55) begin
      bad++; $display("FAIL to_start got %h want 55", start_signal);
    end
    pe_done = 4'b0111;
    step();
    pe_done = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (start_signal !== 8'h80 || busy !== 1'b1 || job_done !== 1'b0) begin
        bad++; $display("FAIL to_run%0d got %h/%b want 80/1", k, start_signal, busy);
      end
      step();
    end
    total++;
    if (start_signal !== 8'hFF || job_done !== 1'b0) begin
      bad++; $display("FAIL to_abort got %h/%b want ff/0", start_signal, job_done);
    end
    step();
    total++;
    if (job_done !== 1'b1 || job_error !== 1'b1 || start_signal !== 8'h00) begin
      bad++; $display("FAIL to_done got d=%b e=%b ss=%h want 1/1/00", job_done, job_error, start_signal);
    end
    step();
    total++;
    if (cycle_count !== 32'd8 || busy !== 1'b0) begin
      bad++; $display("FAIL to_cc got %0d/%b want 8/0", cycle_count, busy);
    end
  endtask

  task automatic test_reset_mid_job();
    logic seen;
    put(1, 1, 1, 0, 0, 0);
    step();
    put(2, 2, 2, 0, 0, 0);
    step();
    job_valid = 1'b0;
    step();
    step();
    total++;
    if (start_signal !== 8'hAA) begin
      bad++; $display("FAIL rmid_run got %h want aa", start_signal);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (start_signal !== 8'h00) begin
      bad++; $display("FAIL rmid_start got %h want 00", start_signal);
    end
    total++;
    if (busy !== 1'b0 || job_ready !== 1'b1 || job_done !== 1'b0) begin
      bad++; $display("FAIL rmid_flags got b=%b r=%b d=%b want 0/1/0", busy, job_ready, job_done);
    end
    step();
    rst = 1'b0;
    total++;
    if (cycle_count !== 0) begin
      bad++; $display("FAIL rmid_cc got %0d want 0", cycle_count);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (job_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rmid_discard got activity=1 want 0");
    end
  endtask

  initial begin
    bm[0] = 1; bn[0] = 1; bp[0] = 1; blo[0] = 0;  bro[0] = 1;  bso[0] = 2;
    bm[1] = 2; bn[1] = 3; bp[1] = 1; blo[1] = 10; bro[1] = 20; bso[1] = 30;
    bm[2] = 3; bn[2] = 1; bp[2] = 2; blo[2] = 40; bro[2] = 50; bso[2] = 60;
    bm[3] = 1; bn[3] = 4; bp[3] = 4; blo[3] = 70; bro[3] = 80; bso[3] = 90;
    rst = 1'b1;
    job_valid = 1'b0;
    job_M = 0; job_N = 0; job_P = 0;
    job_left_offset = 0; job_right_offset = 0; job_result_offset = 0;
    pe_done = 4'h0;
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_single();
    test_reject("oob", 2, 2, 2, 0, 0, 125);
    test_reject("zero_n", 2, 0, 2, 0, 0, 0);
    test_back_to_back();
    test_timeout();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
